// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
//
// Frame sequencer for the UART transmit path. Accepts one data word per
// ready/valid handshake and shifts it out on tx_serial as a start bit, the
// data bits (LSB first), an optional even-parity bit and a stop bit. Each bit
// is held for CLKS_PER_BIT clocks, timed by a baud-period counter. A bit-index
// counter tracks the data bit being sent.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. When the macro is undefined,
// the PARITY state and its logic are absent.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   tx_valid   requester has a word on tx_data
//   tx_data    word to send, sampled only on handshake
//   tx_ready   sequencer can accept a word (IDLE only)
//   tx_serial  serial line, idle high, registered
//   tx_busy    frame in progress, registered
//   tx_done    one-cycle pulse after the stop bit completes, registered
// -----------------------------------------------------------------------------
module uart_tx_sequencer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e                state_q,     state_d;
  logic [BAUD_W-1:0]     baud_cnt_q,  baud_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q,     shift_d;
  logic                  tx_serial_q, tx_serial_d;
  logic                  tx_busy_q,   tx_busy_d;
  logic                  tx_done_q,   tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q,    parity_d;
`endif

  logic bit_end;
  logic accept;

  assign bit_end = (baud_cnt_q == BAUD_LAST);
  assign accept  = tx_valid && (state_q == S_IDLE);

  // Combinational next-state logic for the FSM, both counters and the outputs.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is
    // inferred when a case arm leaves it unassigned.
    state_d     = state_q;
    baud_cnt_d  = '0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Baud counter free-runs and wraps in every active state, held at 0 in IDLE.
    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          // Parity comes from the word as accepted; the shift register is
          // consumed bit by bit and cannot be used later.
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d   = S_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is a function of the state being entered, so tx_serial
    // changes on the same edge as the state register.
    case (state_d)
      S_START:  tx_serial_d = 1'b0;
      S_DATA:   tx_serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_serial_d = parity_d;
`endif
      default:  tx_serial_d = 1'b1;
    endcase

    tx_busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Ready is decoded from the state register so it is high in the tx_done
  // cycle, allowing a held tx_valid to start the next frame immediately.
  assign tx_ready  = (state_q == S_IDLE);
  assign tx_serial = tx_serial_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule
